// File: rtl/ibex_pkg.sv
// ibex_pkg -- shared definitions for the register-file writeback slice.
//
// Contents:
//   wb_state_e     writeback controller FSM state (IDLE, HOLD)
//   REG_ADDR_W     width of a register address
//   num_regs()     architectural register count for a given RV32E setting
package ibex_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wb_state_e;

  // RV32E keeps only x0..x15; the full base ISA has x0..x31.
  function automatic int num_regs(input bit rv32e);
    return rv32e ? 16 : 32;
  endfunction

  // A result is written only if it targets an existing, non-x0 register.
  // Under RV32E any address with bit 4 set is outside the register file
  // and behaves like x0.
  function automatic logic addr_writable(input logic [REG_ADDR_W-1:0] addr,
                                         input bit rv32e);
    return (addr != '0) && !(rv32e && addr[REG_ADDR_W-1]);
  endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// ibex_rf_scoreboard -- busy bits for registers with a write in flight.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   set_valid_i         an instruction with destination set_addr_i issues
//   set_addr_i          destination register to mark busy
//   clr_valid_i         a register-file write happens this cycle
//   clr_addr_i          register being written (its busy bit clears)
//   raddr_a_i/raddr_b_i source registers to look up
//   hazard_a_o/b_o      looked-up register is busy (combinational)
module ibex_rf_scoreboard
  import ibex_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o
);

  localparam int NUM_REGS = num_regs(RV32E);

  // x0 has no storage, so it can never read as busy. Addresses beyond the
  // register count (RV32E) match no bit and likewise never become busy.
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_d;

  // Clear first, then set, so a new issue to a register that is being
  // written in the same cycle keeps it busy for the newer instruction.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clr_valid_i && (clr_addr_i == 5'(i))) busy_d[i] = 1'b0;
      if (set_valid_i && (set_addr_i == 5'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // No bypass: a register reads busy up to the edge ending its write cycle.
  always_comb begin
    hazard_a_o = 1'b0;
    hazard_b_o = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr_a_i == 5'(i)) hazard_a_o = busy_q[i];
      if (raddr_b_i == 5'(i)) hazard_b_o = busy_q[i];
    end
  end

endmodule

// File: rtl/ibex_rf_wb_ctrl.sv
// ibex_rf_wb_ctrl -- arbitrates ALU and load results onto one register-file
// write port and tracks pending writes for hazard detection.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   issue_valid_i, issue_waddr_i    instruction with a destination issues
//   raddr_a_i/b_i, hazard_a_o/b_o   source hazard queries
//   alu_valid_i/alu_ready_o         ALU result handshake (+ waddr, wdata)
//   lsu_valid_i/lsu_ready_o         load result handshake (+ waddr, wdata)
//   rf_waddr_o, rf_wdata_o, rf_we_o registered register-file write port
module ibex_rf_wb_ctrl
  import ibex_pkg::*;
#(
  parameter bit RV32E      = 1'b0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic [4:0]            issue_waddr_i,
  input  logic [4:0]            raddr_a_i,
  input  logic [4:0]            raddr_b_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [4:0]            alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [4:0]            lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_we_o
);

  wb_state_e             state_q;
  logic                  hold_we_q;
  logic [4:0]            hold_waddr_q;
  logic [DATA_WIDTH-1:0] hold_wdata_q;

  logic alu_xfer;
  logic lsu_xfer;
  logic alu_we;
  logic lsu_we;

  // Ready depends on state alone so there is no valid-to-ready path.
  assign alu_ready_o = (state_q == IDLE);
  assign lsu_ready_o = (state_q == IDLE);

  assign alu_xfer = alu_valid_i & alu_ready_o;
  assign lsu_xfer = lsu_valid_i & lsu_ready_o;
  assign alu_we   = addr_writable(alu_waddr_i, RV32E);
  assign lsu_we   = addr_writable(lsu_waddr_i, RV32E);

  // The write port only updates address/data for real writes, so results
  // to x0 (or out-of-range under RV32E) leave the last write visible.
  // On a collision the load wins the port and the ALU result waits one
  // cycle in the hold register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_we_q    <= 1'b0;
      hold_waddr_q <= '0;
      hold_wdata_q <= '0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rf_we_o <= 1'b0;
          if (lsu_xfer) begin
            rf_we_o <= lsu_we;
            if (lsu_we) begin
              rf_waddr_o <= lsu_waddr_i;
              rf_wdata_o <= lsu_wdata_i;
            end
            if (alu_xfer) begin
              hold_we_q    <= alu_we;
              hold_waddr_q <= alu_waddr_i;
              hold_wdata_q <= alu_wdata_i;
              state_q      <= HOLD;
            end
          end else if (alu_xfer) begin
            rf_we_o <= alu_we;
            if (alu_we) begin
              rf_waddr_o <= alu_waddr_i;
              rf_wdata_o <= alu_wdata_i;
            end
          end
        end
        HOLD: begin
          rf_we_o <= hold_we_q;
          if (hold_we_q) begin
            rf_waddr_o <= hold_waddr_q;
            rf_wdata_o <= hold_wdata_q;
          end
          hold_we_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          rf_we_o <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  ibex_rf_scoreboard #(
    .RV32E(RV32E)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid_i(issue_valid_i),
    .set_addr_i (issue_waddr_i),
    .clr_valid_i(rf_we_o),
    .clr_addr_i (rf_waddr_o),
    .raddr_a_i  (raddr_a_i),
    .raddr_b_i  (raddr_b_i),
    .hazard_a_o (hazard_a_o),
    .hazard_b_o (hazard_b_o)
  );

endmodule

// File: tb/tb_ibex_rf_wb_ctrl.sv
// tb_ibex_rf_wb_ctrl -- directed self-checking bench for ibex_rf_wb_ctrl.
// Inputs change 1ns after a rising edge; outputs are observed at that
// point (registered ones reflect the edge just taken).
module tb_ibex_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i;
  logic [4:0]  issue_waddr_i;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        hazard_a_o;
  logic        hazard_b_o;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_we_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibex_rf_wb_ctrl #(
    .RV32E     (1'b0),
    .DATA_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_i(issue_valid_i),
    .issue_waddr_i(issue_waddr_i),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .hazard_a_o   (hazard_a_o),
    .hazard_b_o   (hazard_b_o),
    .alu_valid_i  (alu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .alu_waddr_i  (alu_waddr_i),
    .alu_wdata_i  (alu_wdata_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_waddr_i  (lsu_waddr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_we_o      (rf_we_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_waddr_i = '0;
    alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
    lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    raddr_a_i = 5'd5; raddr_b_i = 5'd0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%b exp=0", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_waddr got=%0d exp=0", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata got=%h exp=0", rf_wdata_o); end
    checks++; if ({alu_ready_o, lsu_ready_o} !== 2'b11) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=11", {alu_ready_o, lsu_ready_o}); end
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin failures++; $display("[TB] FAIL reset_hazard got=%b exp=00", {hazard_a_o, hazard_b_o}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_single();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd5;
    tick();
    issue_valid_i = 1'b0;
    raddr_a_i = 5'd5;
    #1;
    checks++; if (hazard_a_o !== 1'b1) begin failures++; $display("[TB] FAIL alu_busy_set got=%b exp=1", hazard_a_o); end
    alu_valid_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'hDEADBEEF;
    tick();
    alu_valid_i = 1'b0;
    checks++; if (rf_we_o !== 1'b1) begin failures++; $display("[TB] FAIL alu_we got=%b exp=1", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd5) begin failures++; $display("[TB] FAIL alu_waddr got=%0d exp=5", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL alu_wdata got=%h exp=deadbeef", rf_wdata_o); end
    checks++; if (hazard_a_o !== 1'b1) begin failures++; $display("[TB] FAIL alu_busy_during_write got=%b exp=1", hazard_a_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL alu_we_one_cycle got=%b exp=0", rf_we_o); end
    checks++; if (hazard_a_o !== 1'b0) begin failures++; $display("[TB] FAIL alu_busy_cleared got=%b exp=0", hazard_a_o); end
    checks++; if ({rf_waddr_o, rf_wdata_o} !== {5'd5, 32'hDEADBEEF}) begin failures++; $display("[TB] FAIL alu_port_held got=%0d/%h exp=5/deadbeef", rf_waddr_o, rf_wdata_o); end
  endtask

  task automatic test_back_to_back();
    alu_valid_i = 1'b1; alu_waddr_i = 5'd3; alu_wdata_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h22;
    tick();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h22}) begin failures++; $display("[TB] FAIL dual_first got=%b/%0d/%h exp=1/7/22", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if ({alu_ready_o, lsu_ready_o} !== 2'b00) begin failures++; $display("[TB] FAIL dual_hold_ready got=%b exp=00", {alu_ready_o, lsu_ready_o}); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h11}) begin failures++; $display("[TB] FAIL dual_second got=%b/%0d/%h exp=1/3/11", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if ({alu_ready_o, lsu_ready_o} !== 2'b11) begin failures++; $display("[TB] FAIL dual_idle_ready got=%b exp=11", {alu_ready_o, lsu_ready_o}); end
    tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL dual_done_we got=%b exp=0", rf_we_o); end
  endtask

  task automatic test_hazard();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd9;
    tick();
    issue_valid_i = 1'b0;
    raddr_a_i = 5'd9; raddr_b_i = 5'd0;
    #1;
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b10) begin failures++; $display("[TB] FAIL hazard_issue got=%b exp=10", {hazard_a_o, hazard_b_o}); end
    tick(); tick();
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b10) begin failures++; $display("[TB] FAIL hazard_pending got=%b exp=10", {hazard_a_o, hazard_b_o}); end
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'h99;
    tick();
    lsu_valid_i = 1'b0;
    checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd9}) begin failures++; $display("[TB] FAIL hazard_write got=%b/%0d exp=1/9", rf_we_o, rf_waddr_o); end
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b10) begin failures++; $display("[TB] FAIL hazard_write_cycle got=%b exp=10", {hazard_a_o, hazard_b_o}); end
    tick();
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin failures++; $display("[TB] FAIL hazard_cleared got=%b exp=00", {hazard_a_o, hazard_b_o}); end
  endtask

  task automatic test_set_priority();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd4;
    tick();
    issue_valid_i = 1'b0;
    alu_valid_i = 1'b1; alu_waddr_i = 5'd4; alu_wdata_i = 32'h44;
    tick();
    alu_valid_i = 1'b0;
    issue_valid_i = 1'b1; issue_waddr_i = 5'd4;
    raddr_a_i = 5'd4;
    checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd4}) begin failures++; $display("[TB] FAIL prio_write got=%b/%0d exp=1/4", rf_we_o, rf_waddr_o); end
    tick();
    issue_valid_i = 1'b0;
    checks++; if (hazard_a_o !== 1'b1) begin failures++; $display("[TB] FAIL prio_still_busy got=%b exp=1", hazard_a_o); end
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd4; lsu_wdata_i = 32'h40;
    tick();
    lsu_valid_i = 1'b0;
    tick();
    checks++; if (hazard_a_o !== 1'b0) begin failures++; $display("[TB] FAIL prio_final_clear got=%b exp=0", hazard_a_o); end
  endtask

  task automatic test_x0();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd0;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'hAB;
    raddr_a_i = 5'd0;
    #1;
    checks++; if (lsu_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL x0_handshake got=%b exp=1", lsu_ready_o); end
    tick();
    issue_valid_i = 1'b0; lsu_valid_i = 1'b0;
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL x0_we got=%b exp=0", rf_we_o); end
    checks++; if ({rf_waddr_o, rf_wdata_o} !== {5'd4, 32'h40}) begin failures++; $display("[TB] FAIL x0_port_held got=%0d/%h exp=4/40", rf_waddr_o, rf_wdata_o); end
    checks++; if (hazard_a_o !== 1'b0) begin failures++; $display("[TB] FAIL x0_hazard got=%b exp=0", hazard_a_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL x0_we_later got=%b exp=0", rf_we_o); end
  endtask

  task automatic test_reset_in_hold();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd12;
    tick();
    issue_valid_i = 1'b0;
    raddr_a_i = 5'd12; raddr_b_i = 5'd12;
    alu_valid_i = 1'b1; alu_waddr_i = 5'd3; alu_wdata_i = 32'h33;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h77;
    tick();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    checks++; if ({rf_we_o, rf_waddr_o, alu_ready_o} !== {1'b1, 5'd7, 1'b0}) begin failures++; $display("[TB] FAIL rsthold_enter got=%b/%0d/%b exp=1/7/0", rf_we_o, rf_waddr_o, alu_ready_o); end
    checks++; if (hazard_a_o !== 1'b1) begin failures++; $display("[TB] FAIL rsthold_busy got=%b exp=1", hazard_a_o); end
    rst_n = 1'b0;
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd0, 32'h0}) begin failures++; $display("[TB] FAIL rsthold_port got=%b/%0d/%h exp=0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if ({alu_ready_o, lsu_ready_o, hazard_a_o, hazard_b_o} !== 4'b1100) begin failures++; $display("[TB] FAIL rsthold_ready_hazard got=%b exp=1100", {alu_ready_o, lsu_ready_o, hazard_a_o, hazard_b_o}); end
    rst_n = 1'b1;
    tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL rsthold_no_held_write got=%b exp=0", rf_we_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("[TB] FAIL rsthold_quiet got=%b exp=0", rf_we_o); end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_back_to_back();
    test_hazard();
    test_set_priority();
    test_x0();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wb_ctrl.md
IBEX_RF_WB_CTRL -- requirements
Module: ibex_rf_wb_ctrl

Interface
REQ-001 SHALL have parameter RV32E, default 0, meaning 16 architectural registers when 1, otherwise 32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning writeback data width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port issue_valid_i  in  1  an instruction with a destination register issues this cycle.
REQ-006 SHALL have port issue_waddr_i  in  5  destination register of the issuing instruction.
REQ-007 SHALL have port raddr_a_i / raddr_b_i  in  5 each  source registers queried for hazards.
REQ-008 SHALL have port hazard_a_o / hazard_b_o  out  1 each  queried source has a pending write.
REQ-009 SHALL have port alu_valid_i / alu_ready_o  in / out  1 each  ALU result handshake.
REQ-010 SHALL have port alu_waddr_i, alu_wdata_i  in  5, DATA_WIDTH  ALU result destination and data.
REQ-011 SHALL have port lsu_valid_i / lsu_ready_o  in / out  1 each  load result handshake.
REQ-012 SHALL have port lsu_waddr_i, lsu_wdata_i  in  5, DATA_WIDTH  load result destination and data.
REQ-013 SHALL have port rf_waddr_o, rf_wdata_o, rf_we_o  out  5, DATA_WIDTH, 1  register-file write port, all registered.

Function
REQ-014 SHALL run a two-state FSM, IDLE and HOLD.
REQ-015 SHALL drive alu_ready_o = lsu_ready_o = 1 in IDLE and 0 in HOLD, decoded from state only, with no valid-to-ready path.
REQ-016 SHALL define a transfer as valid & ready sampled at a rising edge.
REQ-017 SHALL, in IDLE with a single transfer, register its address and data onto rf_* and assert rf_we_o in the next cycle, giving latency 1.
REQ-018 SHALL, in IDLE with simultaneous ALU and LSU transfers, write the LSU result next cycle, capture the ALU result in a one-entry hold register, and move to HOLD.
REQ-019 SHALL, in HOLD, write the held entry next cycle and return to IDLE unconditionally; the held ALU write therefore appears 2 cycles after acceptance.
REQ-020 SHALL assert rf_we_o for exactly one cycle per accepted result with waddr != 0, and hold rf_we_o at 0 in every other cycle.
REQ-021 SHALL complete the handshake for a result with waddr == 0 but suppress rf_we_o for it.
REQ-022 SHALL, when RV32E=1, treat waddr bit 4 = 1 like x0: accept the result, suppress the write, never mark it busy, and report hazard 0.
REQ-023 SHALL, while rf_we_o = 0, hold rf_waddr_o and rf_wdata_o at their last values.
REQ-024 SHALL keep one busy bit per register 1..NUM-1, where x0 is never busy.
REQ-025 SHALL set busy[issue_waddr_i] at the edge where issue_valid_i = 1 and issue_waddr_i != 0.
REQ-026 SHALL clear busy[rf_waddr_o] at the end of the cycle in which rf_we_o = 1.
REQ-027 SHALL give set priority when set and clear target the same register in the same cycle, so the register stays busy.
REQ-028 SHALL make hazard_x_o combinational: busy[raddr_x_i], forced 0 for address 0.
REQ-029 SHALL reflect a write in its busy bit until the edge that ends its rf_we_o cycle, with no bypass.

Reset
REQ-030 SHALL, on the edge with rst_n = 0, set state IDLE, clear all busy bits, clear the hold register, and set rf_we_o, rf_waddr_o and rf_wdata_o to 0.
REQ-031 SHALL, on reset in HOLD, discard the held entry with no write.
REQ-032 SHALL hold alu_ready_o = lsu_ready_o = 1 and hazard_a_o = hazard_b_o = 0 after reset.

Structure
REQ-033 SHALL define the FSM state typedef and the register-count constant derived from RV32E in the shared ibex_pkg.
REQ-034 SHALL implement the busy-bit array, its set/clear logic and the two hazard lookups as sub-module ibex_rf_scoreboard.

Verification
REQ-035 SHALL cover: ALU only, waddr=5, wdata=0xDEADBEEF -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; busy[5] cleared after that cycle.
REQ-036 SHALL cover: ALU (x3, 0x11) and LSU (x7, 0x22) in the same cycle -> cycle+1 writes x7=0x22, cycle+2 writes x3=0x11; both readys 0 during HOLD.
REQ-037 SHALL cover: issue x9, then query raddr_a_i=9 -> hazard_a_o=1 until the x9 write cycle ends; raddr_b_i=0 -> hazard_b_o=0 throughout.
REQ-038 SHALL cover: issue x4 in the same cycle an older x4 result writes -> busy[4] remains 1.
REQ-039 SHALL cover: LSU result to x0 -> lsu handshake completes and rf_we_o stays 0.
REQ-040 SHALL cover: rst_n=0 while in HOLD -> held write never appears, rf_we_o=0, all hazards 0, both readys 1 next cycle.
